// File: rtl/mem_access.sv
// Memory-stage load/store unit: single-outstanding req/gnt/rvalid data bus,
// lane-replicated stores, extracted/extended loads, and alignment/type traps.
module mem_access #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              is_ls,
    input  logic [XLEN+3:0]   ls_type_reg,
    input  logic [XLEN-1:0]   rd_val,
    output logic              ls_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   mem_rd_val,
    output logic              ls_fault,
    output logic [1:0]        fault_cause,
    output logic [XLEN-1:0]   bad_addr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        type_reg;
    logic [1:0]        off_reg;
    logic [4:0]        rd_reg;

    logic [3:0]        req_type;
    logic [XLEN-1:0]   req_addr;
    logic              req_byte, req_half, req_word;
    logic              req_illegal, req_misaligned, req_fault, accept;
    logic [3:0]        req_be;
    logic [XLEN-1:0]   req_wdata;

    logic [7:0]        rd_byte [4];
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [XLEN-1:0]   load_ext;

    assign req_type = ls_type_reg[XLEN+3:XLEN];
    assign req_addr = ls_type_reg[XLEN-1:0];
    assign accept   = is_ls && (state_reg == IDLE);

    // Request decode: access size, trap conditions, bus lane setup.
    always_comb begin
        req_byte  = (req_type[2:0] == 3'b000) || (req_type[2:0] == 3'b100);
        req_half  = (req_type[2:0] == 3'b001) || (req_type[2:0] == 3'b110);
        req_word  = (req_type[2:0] == 3'b010);
        // Covers 0011/1011/0111/1111, 0101/1101 and every 11xx.
        req_illegal = (req_type[3:2] == 2'b11) || (req_type[1:0] == 2'b11)
                    || (req_type[2:0] == 3'b101);
        req_misaligned = (req_half && req_addr[0])
                       || (req_word && (req_addr[1:0] != 2'b00));
        req_fault = req_illegal || req_misaligned;

        req_be = 4'b0000;
        if (req_byte)
            req_be = 4'b0001 << req_addr[1:0];
        else if (req_half)
            req_be = req_addr[1] ? 4'b1100 : 4'b0011;
        else if (req_word)
            req_be = 4'b1111;

        req_wdata = '0;
        if (req_type[3]) begin
            if (req_byte)
                req_wdata = {4{rd_val[7:0]}};
            else if (req_half)
                req_wdata = {2{rd_val[15:0]}};
            else
                req_wdata = rd_val;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = dmem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        sel_byte = rd_byte[off_reg];
        sel_half = off_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (type_reg)
            3'b000:  load_ext = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, sel_byte};
            3'b001:  load_ext = {{(XLEN-16){sel_half[15]}}, sel_half};
            3'b110:  load_ext = {{(XLEN-16){1'b0}}, sel_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        ls_ready   = 1'b0;
        dmem_req   = 1'b0;
        case (state_reg)
            IDLE: begin
                ls_ready = 1'b1;
                if (is_ls && !req_fault)
                    state_next = REQ;
            end
            REQ: begin
                dmem_req = 1'b1;
                if (dmem_gnt)
                    state_next = dmem_we ? IDLE : WAIT;
            end
            WAIT: begin
                if (dmem_rvalid)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus fields are captured at accept so they stay stable through a gnt stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= 4'b0000;
            dmem_wdata  <= '0;
            type_reg    <= 3'b000;
            off_reg     <= 2'b00;
            rd_reg      <= 5'd0;
            wb_valid    <= 1'b0;
            wb_rd       <= 5'd0;
            mem_rd_val  <= '0;
            ls_fault    <= 1'b0;
            fault_cause <= 2'b00;
            bad_addr    <= '0;
        end else begin
            ls_fault <= 1'b0;
            wb_valid <= 1'b0;
            if (accept) begin
                if (req_fault) begin
                    ls_fault    <= 1'b1;
                    fault_cause <= req_illegal ? 2'b10 : 2'b01;
                    bad_addr    <= req_addr;
                end else begin
                    dmem_we    <= req_type[3];
                    dmem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                    dmem_be    <= req_be;
                    dmem_wdata <= req_wdata;
                    type_reg   <= req_type[2:0];
                    off_reg    <= req_addr[1:0];
                    rd_reg     <= rd_val[4:0];
                end
            end
            if ((state_reg == WAIT) && dmem_rvalid) begin
                mem_rd_val <= load_ext;
                wb_rd      <= rd_reg;
                wb_valid   <= (rd_reg != 5'd0);
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a vector table of single transactions plus
// hand-written reset-abort sequences.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        is_ls;
    logic [35:0] ls_type_reg;
    logic [31:0] rd_val;
    logic        ls_ready;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] mem_rd_val;
    logic        ls_fault;
    logic [1:0]  fault_cause;
    logic [31:0] bad_addr;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_access #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .is_ls(is_ls), .ls_type_reg(ls_type_reg),
        .rd_val(rd_val), .ls_ready(ls_ready), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .mem_rd_val(mem_rd_val), .ls_fault(ls_fault), .fault_cause(fault_cause),
        .bad_addr(bad_addr)
    );

    typedef struct {
        logic [3:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;      // store data or rd number
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        exp_fault;
        logic [1:0]  exp_cause;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] exp_addr;
        exp_addr = {v.addr[31:2], 2'b00};
        chk("ready_before", 32'(ls_ready), 32'd1);
        is_ls = 1'b1;
        ls_type_reg = {v.typ, v.addr};
        rd_val = v.data;
        step();
        is_ls = 1'b0;
        if (v.exp_fault) begin
            chk("fault_req", 32'(dmem_req), 32'd0);
            chk("fault_pulse", 32'(ls_fault), 32'd1);
            chk("fault_cause", 32'(fault_cause), 32'(v.exp_cause));
            chk("bad_addr", bad_addr, v.addr);
            chk("fault_ready", 32'(ls_ready), 32'd1);
            step();
            chk("fault_pulse_end", 32'(ls_fault), 32'd0);
        end else begin
            for (int c = 0; c <= v.gnt_dly; c++) begin
                chk("req", 32'(dmem_req), 32'd1);
                chk("we", 32'(dmem_we), 32'(v.typ[3]));
                chk("addr", dmem_addr, exp_addr);
                chk("be", 32'(dmem_be), 32'(v.exp_be));
                chk("wdata", dmem_wdata, v.exp_wdata);
                chk("busy", 32'(ls_ready), 32'd0);
                if (c < v.gnt_dly) begin
                    // a competing request while busy must not be taken
                    is_ls = 1'b1;
                    ls_type_reg = {4'b1010, 32'h0000_0F00};
                    rd_val = 32'h5555_5555;
                    dmem_gnt = 1'b0;
                    step();
                    is_ls = 1'b0;
                end
            end
            dmem_gnt = 1'b1;
            step();
            dmem_gnt = 1'b0;
            if (v.typ[3]) begin
                chk("st_ready", 32'(ls_ready), 32'd1);
                chk("st_req_off", 32'(dmem_req), 32'd0);
            end else begin
                for (int c = 0; c < v.rv_dly; c++) begin
                    chk("wait_busy", 32'(ls_ready), 32'd0);
                    chk("wait_req_off", 32'(dmem_req), 32'd0);
                    dmem_rdata = 32'hBAD0_BAD0;
                    step();
                    chk("wait_no_wb", 32'(wb_valid), 32'd0);
                end
                dmem_rdata = v.rdata;
                dmem_rvalid = 1'b1;
                step();
                dmem_rvalid = 1'b0;
                chk("wb_valid", 32'(wb_valid), 32'(v.data[4:0] != 5'd0));
                chk("mem_rd_val", mem_rd_val, v.exp_val);
                if (v.data[4:0] != 5'd0)
                    chk("wb_rd", 32'(wb_rd), 32'(v.data[4:0]));
                chk("ld_ready", 32'(ls_ready), 32'd1);
                step();
                chk("wb_pulse_end", 32'(wb_valid), 32'd0);
            end
        end
        $display("[TB] vec %0d type=%b addr=%h done, failures so far %0d", idx, v.typ, v.addr, failed);
    endtask

    initial begin
        // typ, addr, data, rdata, gnt_dly, rv_dly, fault, cause, be, wdata, val
        vecs[0]  = '{4'b1010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 2'b00, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{4'b1000, 32'h103, 32'h000000A5, 32'h0, 0, 0, 1'b0, 2'b00, 4'b1000, 32'hA5A5A5A5, 32'h0};
        vecs[2]  = '{4'b1001, 32'h102, 32'h1234ABCD, 32'h0, 1, 0, 1'b0, 2'b00, 4'b1100, 32'hABCDABCD, 32'h0};
        vecs[3]  = '{4'b0000, 32'h101, 32'd5, 32'h00008000, 0, 0, 1'b0, 2'b00, 4'b0010, 32'h0, 32'hFFFFFF80};
        vecs[4]  = '{4'b0100, 32'h101, 32'd5, 32'h00008000, 0, 0, 1'b0, 2'b00, 4'b0010, 32'h0, 32'h00000080};
        vecs[5]  = '{4'b0110, 32'h102, 32'd6, 32'h80010000, 0, 0, 1'b0, 2'b00, 4'b1100, 32'h0, 32'h00008001};
        vecs[6]  = '{4'b0001, 32'h102, 32'd6, 32'h80010000, 0, 1, 1'b0, 2'b00, 4'b1100, 32'h0, 32'hFFFF8001};
        vecs[7]  = '{4'b0010, 32'h104, 32'd7, 32'h12345678, 0, 0, 1'b0, 2'b00, 4'b1111, 32'h0, 32'h12345678};
        vecs[8]  = '{4'b0010, 32'h102, 32'd7, 32'h0, 0, 0, 1'b1, 2'b01, 4'b0000, 32'h0, 32'h0};
        vecs[9]  = '{4'b0111, 32'h100, 32'd7, 32'h0, 0, 0, 1'b1, 2'b10, 4'b0000, 32'h0, 32'h0};
        vecs[10] = '{4'b1100, 32'h101, 32'd7, 32'h0, 0, 0, 1'b1, 2'b10, 4'b0000, 32'h0, 32'h0};
        vecs[11] = '{4'b1001, 32'h101, 32'h1, 32'h0, 0, 0, 1'b1, 2'b01, 4'b0000, 32'h0, 32'h0};
        vecs[12] = '{4'b0000, 32'h100, 32'd0, 32'h0000007F, 0, 0, 1'b0, 2'b00, 4'b0001, 32'h0, 32'h0000007F};
        vecs[13] = '{4'b0010, 32'h108, 32'd9, 32'hCAFEF00D, 3, 2, 1'b0, 2'b00, 4'b1111, 32'h0, 32'hCAFEF00D};

        rst_n = 1'b0;
        is_ls = 1'b0;
        ls_type_reg = '0;
        rd_val = '0;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        #1;
        chk("rst_ready", 32'(ls_ready), 32'd1);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_wb", 32'(wb_valid), 32'd0);
        chk("rst_fault", 32'(ls_fault), 32'd0);
        chk("rst_rdval", mem_rd_val, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++)
            run_vec(i, vecs[i]);

        // Reset while REQ is pending drops the bus request at once.
        is_ls = 1'b1;
        ls_type_reg = {4'b0010, 32'h0000_0200};
        rd_val = 32'd3;
        step();
        is_ls = 1'b0;
        chk("abort_req_before", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_req_drop", 32'(dmem_req), 32'd0);
        chk("abort_ready", 32'(ls_ready), 32'd1);
        chk("abort_addr", dmem_addr, 32'd0);
        chk("abort_rdval", mem_rd_val, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        $display("[TB] reset during REQ done, failures so far %0d", failed);

        // Reset in WAIT, then a late rvalid for the aborted load.
        is_ls = 1'b1;
        ls_type_reg = {4'b0010, 32'h0000_0300};
        rd_val = 32'd4;
        step();
        is_ls = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        chk("wait_state", 32'(ls_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("waitrst_ready", 32'(ls_ready), 32'd1);
        chk("waitrst_be", 32'(dmem_be), 32'd0);
        step();
        rst_n = 1'b1;
        dmem_rdata = 32'h1111_2222;
        dmem_rvalid = 1'b1;
        step();
        dmem_rvalid = 1'b0;
        chk("late_rv_wb", 32'(wb_valid), 32'd0);
        chk("late_rv_val", mem_rd_val, 32'd0);
        chk("late_rv_rd", 32'(wb_rd), 32'd0);
        chk("late_rv_ready", 32'(ls_ready), 32'd1);
        $display("[TB] reset during WAIT done, failures so far %0d", failed);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
